// File: rtl/gear_shift_ctrl.sv
// Gear shift sequencer: debounces the decoded gear request, runs a clutch req/ack
// handshake with timeout, steps the gear and enforces dwell. Optional GEAR_SKIP_EN jumps straight to target.
module gear_shift_ctrl #(
  parameter int STABLE_CYC  = 4,
  parameter int DWELL_CYC   = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gear_req,
  input  logic       req_valid,
  input  logic       clutch_ack,
  output logic       clutch_req,
  output logic [1:0] gear_cur,
  output logic       shifting,
  output logic       fault,
  output logic [7:0] shift_cnt
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam int TMAX   = (ACK_TIMEOUT > DWELL_CYC) ? ACK_TIMEOUT : DWELL_CYC;
  localparam int TMR_W  = $clog2(TMAX + 1);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
  localparam logic [TMR_W-1:0]  ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  DWL_LAST = TMR_W'(DWELL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLUTCH,
    S_ENGAGE,
    S_DWELL,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cand_q, cand_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              clutch_req_q, clutch_req_d;
  logic [1:0]        gear_cur_q, gear_cur_d;
  logic              fault_q, fault_d;
  logic [7:0]        shift_cnt_q, shift_cnt_d;
  logic              tgt_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cand_q       <= '0;
      stab_cnt_q   <= '0;
      timer_q      <= '0;
      clutch_req_q <= 1'b0;
      gear_cur_q   <= '0;
      fault_q      <= 1'b0;
      shift_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      stab_cnt_q   <= stab_cnt_d;
      timer_q      <= timer_d;
      clutch_req_q <= clutch_req_d;
      gear_cur_q   <= gear_cur_d;
      fault_q      <= fault_d;
      shift_cnt_q  <= shift_cnt_d;
    end
  end

  // Debounce runs in every state, including FAULT.
  always_comb begin
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (req_valid && (gear_req == cand_q)) begin
      if (stab_cnt_q != STAB_MAX) stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end else begin
      cand_d     = gear_req;
      stab_cnt_d = req_valid ? STAB_W'(1) : '0;
    end
  end

  assign tgt_ok = (stab_cnt_q == STAB_MAX);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    clutch_req_d = clutch_req_q;
    gear_cur_d   = gear_cur_q;
    fault_d      = fault_q;
    shift_cnt_d  = shift_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (tgt_ok && (cand_q != gear_cur_q)) begin
          state_d      = S_CLUTCH;
          clutch_req_d = 1'b1;
          timer_d      = '0;
        end
      end
      S_CLUTCH: begin
        if (clutch_ack) begin
          state_d = S_ENGAGE;
        end else if (timer_q == ACK_LAST) begin
          state_d      = S_FAULT;
          clutch_req_d = 1'b0;
          fault_d      = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_ENGAGE: begin
        state_d      = S_DWELL;
        clutch_req_d = 1'b0;
        timer_d      = '0;
        // Target is re-read here; a withdrawn request leaves gear and count alone.
        if (cand_q != gear_cur_q) begin
`ifdef GEAR_SKIP_EN
          gear_cur_d = cand_q;
`else
          gear_cur_d = (cand_q > gear_cur_q) ? gear_cur_q + 2'd1 : gear_cur_q - 2'd1;
`endif
          if (shift_cnt_q != 8'hFF) shift_cnt_d = shift_cnt_q + 8'd1;
        end
      end
      S_DWELL: begin
        if (timer_q == DWL_LAST) state_d = S_IDLE;
        else                     timer_d = timer_q + TMR_W'(1);
      end
      S_FAULT: begin
        clutch_req_d = 1'b0;
        fault_d      = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clutch_req = clutch_req_q;
  assign gear_cur   = gear_cur_q;
  assign fault      = fault_q;
  assign shift_cnt  = shift_cnt_q;
  assign shifting   = (state_q == S_CLUTCH) || (state_q == S_ENGAGE) || (state_q == S_DWELL);

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Bench for gear_shift_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the shift sequence.
module tb_gear_shift_ctrl;

  localparam int STABLE = 4;
  localparam int DWELL  = 8;
  localparam int ACK_TO = 16;

  logic       clk;
  logic       rst;
  logic [1:0] gear_req;
  logic       req_valid;
  logic       clutch_ack;
  logic       clutch_req;
  logic [1:0] gear_cur;
  logic       shifting;
  logic       fault;
  logic [7:0] shift_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int m_last, m_run, m_gear, m_cnt, m_wait, m_dwell;
  bit m_clutch, m_engage, m_faulted, m_creq;

  // ack responder
  int ack_cnt = 0;
  int ack_dly = 2;
  bit ack_en  = 1;
  bit rnd_ack = 0;

  gear_shift_ctrl #(
    .STABLE_CYC (STABLE),
    .DWELL_CYC  (DWELL),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gear_req  (gear_req),
    .req_valid (req_valid),
    .clutch_ack(clutch_ack),
    .clutch_req(clutch_req),
    .gear_cur  (gear_cur),
    .shifting  (shifting),
    .fault     (fault),
    .shift_cnt (shift_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_last = 0; m_run = 0; m_gear = 0; m_cnt = 0; m_wait = 0; m_dwell = 0;
    m_clutch = 0; m_engage = 0; m_faulted = 0; m_creq = 0;
    ack_cnt = 0;
  endtask

  task automatic model_step(input int req, input bit valid, input bit ack);
    bit ok;
    int tgt;
    ok  = (m_run == STABLE);
    tgt = m_last;
    if (m_faulted) begin
    end else if (m_clutch) begin
      if (ack) begin
        m_clutch = 0;
        m_engage = 1;
      end else begin
        m_wait++;
        if (m_wait >= ACK_TO) begin
          m_clutch = 0; m_faulted = 1; m_creq = 0;
        end
      end
    end else if (m_engage) begin
      m_engage = 0; m_creq = 0; m_dwell = DWELL;
      if (tgt != m_gear) begin
`ifdef GEAR_SKIP_EN
        m_gear = tgt;
`else
        m_gear = m_gear + ((tgt > m_gear) ? 1 : -1);
`endif
        if (m_cnt < 255) m_cnt++;
      end
    end else if (m_dwell > 0) begin
      m_dwell--;
    end else if (ok && tgt != m_gear) begin
      m_clutch = 1; m_wait = 0; m_creq = 1;
    end
    if (valid && req == m_last) begin
      if (m_run < STABLE) m_run++;
    end else begin
      m_last = req;
      m_run  = valid ? 1 : 0;
    end
  endtask

  task automatic cmp_all();
    check("gear_cur",   32'(gear_cur),   32'(m_gear));
    check("clutch_req", 32'(clutch_req), 32'(m_creq));
    check("shifting",   32'(shifting),   32'(m_clutch || m_engage || (m_dwell > 0)));
    check("fault",      32'(fault),      32'(m_faulted));
    check("shift_cnt",  32'(shift_cnt),  32'(m_cnt));
  endtask

  // Called at edge+1: drives ack, takes one clock edge, advances the model, compares.
  task automatic tick();
    if (m_creq) begin
      ack_cnt++;
      if (rnd_ack && ack_cnt == 1)
        ack_dly = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(1, 6));
      clutch_ack = ack_en && (ack_cnt >= ack_dly);
    end else begin
      ack_cnt    = 0;
      clutch_ack = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(posedge clk);
    model_step(int'(gear_req), req_valid, clutch_ack);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    cmp_all();
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; gear_req = 2'd0; req_valid = 1'b0; clutch_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gear",  32'(gear_cur),   32'd0);
    check("rst_creq",  32'(clutch_req), 32'd0);
    check("rst_cnt",   32'(shift_cnt),  32'd0);
    check("rst_fault", 32'(fault),      32'd0);
    check("rst_shift", 32'(shifting),   32'd0);
    rst = 1'b1;

    // async reset while waiting in CLUTCH
    ack_dly = 100; gear_req = 2'd2; req_valid = 1'b1;
    repeat (7) tick();
    check("pre_rst_creq", 32'(clutch_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_creq",  32'(clutch_req), 32'd0);
    check("async_shift", 32'(shifting),   32'd0);
    check("async_gear",  32'(gear_cur),   32'd0);
    model_reset();
    #1 rst = 1'b1;

    // single step 0->1, latency and dwell
    ack_dly = 2; gear_req = 2'd1;
    repeat (4) tick();
    check("lat_creq_lo", 32'(clutch_req), 32'd0);
    tick();
    check("lat_creq_hi", 32'(clutch_req), 32'd1);
    repeat (10) tick();
    check("dwell_shift_hi", 32'(shifting), 32'd1);
    tick();
    check("dwell_shift_lo", 32'(shifting),  32'd0);
    check("step_gear",      32'(gear_cur),  32'd1);
    check("step_cnt",       32'(shift_cnt), 32'd1);

    // toggling request never settles
    for (int i = 0; i < 24; i++) begin
      gear_req = ((i / 2) % 2 == 1) ? 2'd1 : 2'd0;
      tick();
    end
    check("toggle_creq", 32'(clutch_req), 32'd0);
    check("toggle_gear", 32'(gear_cur),   32'd1);

    // multi-gear request 0->3
    do_reset();
    gear_req = 2'd3;
    repeat (60) tick();
    check("multi_gear", 32'(gear_cur), 32'd3);
`ifdef GEAR_SKIP_EN
    check("multi_cnt", 32'(shift_cnt), 32'd1);
`else
    check("multi_cnt", 32'(shift_cnt), 32'd3);
`endif

    // ack timeout
    do_reset();
    ack_en = 0; gear_req = 2'd2;
    repeat (20) tick();
    check("to_fault_lo", 32'(fault), 32'd0);
    tick();
    check("to_fault_hi", 32'(fault),      32'd1);
    check("to_creq",     32'(clutch_req), 32'd0);
    gear_req = 2'd1;
    repeat (20) tick();
    check("to_sticky", 32'(fault),    32'd1);
    check("to_gear",   32'(gear_cur), 32'd0);
    ack_en = 1;

    // request withdrawn during CLUTCH
    do_reset();
    ack_dly = 6; gear_req = 2'd1;
    repeat (5) tick();
    gear_req = 2'd0;
    repeat (25) tick();
    check("wd_gear",  32'(gear_cur),  32'd0);
    check("wd_cnt",   32'(shift_cnt), 32'd0);
    check("wd_shift", 32'(shifting),  32'd0);

    // shift counter saturation
    do_reset();
    ack_dly = 2;
    for (int i = 0; i < 260; i++) begin
      gear_req = (i % 2 == 0) ? 2'd1 : 2'd0;
      repeat (20) tick();
    end
    check("sat_cnt", 32'(shift_cnt), 32'd255);

    // randomized traffic
    rnd_ack = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) do_reset();
      if ($urandom_range(0, 9) == 0) gear_req = 2'($urandom_range(0, 3));
      req_valid = ($urandom_range(0, 11) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
